// File: rtl/seq_detect_pkg.sv
// Package: seq_detect_pkg
// Shared types and defaults for the 1011 sequence-detector controller slice.
//   state_t      : controller FSM states (IDLE, SHIFT, DONE)
//   PAT_W_DEF    : default pattern length in bits
//   PATTERN_DEF  : default pattern, MSB is the first bit received
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                   PAT_W_DEF   = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/seq_detect_ctrl_matcher.sv
// Module: pattern_matcher
// Mealy matcher over a serial bit stream. Keeps the last PAT_W-1 valid bits
// and flags a hit in the same cycle the final pattern bit is presented.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear_hist  : synchronous history clear (wins over shifting)
//   bit_in      : serial bit
//   bit_valid   : bit_in is meaningful; history only advances when set
//   ovl         : 1 = overlapping matches, 0 = history restarts after a hit
//   hit         : combinational match flag
module pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_hist,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic ovl,
  output logic hit
);

  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] window;

  // Newest bit sits in the LSB, so the oldest history bit lines up with the
  // pattern MSB (the first pattern bit on the wire).
  assign window = {hist, bit_in};
  assign hit    = bit_valid & (window == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
    end else if (clear_hist) begin
      hist <= '0;
    end else if (bit_valid) begin
      if (hit && !ovl) hist <= '0;
      else             hist <= window[PAT_W-2:0];
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Module: seq_detect_ctrl
// Accepts WORD_W-bit words over valid/ready, serialises them MSB-first into
// a pattern matcher, counts hits per packet and pulses done at packet end.
// Optional feature macro: HIT_POS_EN (adds hit_pos, bit index of latest hit).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   clear                : sync clear of count/history, aborts the packet
//   in_valid/in_ready    : word handshake; in_data, in_last ride with it
//   mode_ovl             : overlap mode, latched on a packet's first word
//   x_out/x_valid        : serial bit stream to the detector
//   hit                  : Mealy match flag on the final pattern bit
//   hit_count            : saturating hits in current/last packet
//   done                 : one-cycle pulse after the packet's last bit
//   state_dbg            : current FSM state
//   hit_pos [HIT_POS_EN] : packet-relative index of the most recent hit
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both high; in_valid/in_data/in_last/mode_ovl must be held stable until
// that edge, and in_ready never depends on in_valid.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              mode_ovl,
  output logic              x_out,
  output logic              x_valid,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              done,
  output state_t            state_dbg
`ifdef HIT_POS_EN
  , output logic [15:0]     hit_pos
`endif
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shift_q;
  logic [BC_W-1:0]   bit_cnt;
  logic              last_q;
  logic              ovl_q;
  logic              pkt_open;
  logic [CNT_W-1:0]  hit_count_q;
  logic              last_bit;
  logic              accept;
  logic              first_word;

  assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
  assign accept     = in_valid & in_ready;
  assign first_word = accept & ~pkt_open;
  assign state_dbg  = state;
  assign hit_count  = hit_count_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; clear overrides everything including a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (last_q)      state_nxt = DONE;
          else if (accept) state_nxt = SHIFT;
          else             state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Output decode. in_ready is also offered on the final bit of a non-last
  // word so consecutive words stream without a gap; clear masks it so a
  // word offered during clear is never reported as taken.
  always_comb begin
    in_ready = 1'b0;
    x_valid  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    in_ready = ~clear;
      SHIFT: begin
        x_valid  = 1'b1;
        in_ready = ~clear & last_bit & ~last_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    x_out = x_valid & shift_q[WORD_W-1];
  end

  // Serialiser and packet tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
      ovl_q    <= 1'b0;
      pkt_open <= 1'b0;
    end else if (clear) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
      pkt_open <= 1'b0;
    end else begin
      if (accept) begin
        shift_q  <= in_data;
        bit_cnt  <= BC_W'(WORD_W - 1);
        last_q   <= in_last;
        pkt_open <= 1'b1;
        if (!pkt_open) ovl_q <= mode_ovl;
      end else if (state == SHIFT) begin
        shift_q <= shift_q << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (state == DONE) pkt_open <= 1'b0;
    end
  end

  // Hit counter: zeroed at packet start, holds after done, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          hit_count_q <= '0;
    else if (clear)                     hit_count_q <= '0;
    else if (first_word)                hit_count_q <= '0;
    else if (hit && hit_count_q != '1)  hit_count_q <= hit_count_q + 1'b1;
  end

  pattern_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk        (clk),
    .reset      (reset),
    .clear_hist (clear | (state == DONE)),
    .bit_in     (x_out),
    .bit_valid  (x_valid),
    .ovl        (ovl_q),
    .hit        (hit)
  );

`ifdef HIT_POS_EN
  logic [15:0] bit_idx;
  logic [15:0] hit_pos_q;

  assign hit_pos = hit_pos_q;

  // bit_idx counts streamed bits of the packet and wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      hit_pos_q <= '0;
    end else if (clear || first_word) begin
      bit_idx   <= '0;
      hit_pos_q <= '0;
    end else if (x_valid) begin
      bit_idx <= bit_idx + 16'd1;
      if (hit) hit_pos_q <= bit_idx;
    end
  end
`else
  // No hit position tracking in this build.
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int               WORD_W  = 8;
  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        mode_ovl = 1'b1;

  logic        in_ready, x_out, x_valid, hit, done;
  logic [7:0]  hit_count;
  state_t      state_dbg;
  logic        in_ready_s, x_out_s, x_valid_s, hit_s, done_s;
  logic [1:0]  hit_count_s;
  state_t      state_dbg_s;
`ifdef HIT_POS_EN
  logic [15:0] hit_pos, hit_pos_s;
`endif

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mode_ovl(mode_ovl), .x_out(x_out), .x_valid(x_valid), .hit(hit),
    .hit_count(hit_count), .done(done), .state_dbg(state_dbg)
`ifdef HIT_POS_EN
    , .hit_pos(hit_pos)
`endif
  );

  seq_detect_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .mode_ovl(mode_ovl), .x_out(x_out_s), .x_valid(x_valid_s), .hit(hit_s),
    .hit_count(hit_count_s), .done(done_s), .state_dbg(state_dbg_s)
`ifdef HIT_POS_EN
    , .hit_pos(hit_pos_s)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the bits still to be streamed: [0] = bit, [1] = final bit of packet.
  logic [1:0] exp_q[$];
  logic       win_q[$];     // bits seen since packet start / last non-overlap hit
  int         hit_log[$];   // packet-relative indices of hits in current packet
  int         m_count;
  int         m_bitidx;
  int         m_hitpos;
  bit         m_ovl;
  bit         m_pkt_open;
  bit         m_done;

  function automatic void model_reset();
    exp_q.delete();
    win_q.delete();
    hit_log.delete();
    m_count = 0; m_bitidx = 0; m_hitpos = 0;
    m_pkt_open = 0; m_done = 0;
  endfunction

  // Does the newest bit complete the pattern given what came before in the packet?
  function automatic bit pattern_hit(input logic b);
    logic [PAT_W-1:0] v;
    int n;
    v = '0;
    v[0] = b;
    n = win_q.size();
    for (int k = 1; k < PAT_W; k++)
      if (n - k >= 0) v[k] = win_q[n-k];
    return v == PATTERN;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  initial model_reset();

  // One compare process: check outputs mid-cycle, then advance the model by the
  // edge that follows, using the inputs the bench is holding for that edge.
  always @(negedge clk) begin
    bit         exp_xv, exp_hit, exp_rdy, handshake, done_next;
    logic       exp_x;
    logic [1:0] e;
    state_t     exp_st;
    if (reset) begin
      model_reset();
    end else begin
      exp_xv  = exp_q.size() > 0;
      exp_x   = exp_xv ? exp_q[0][0] : 1'b0;
      exp_hit = exp_xv && pattern_hit(exp_x);
      exp_rdy = !clear && ((exp_q.size() == 0 && !m_done) ||
                           (exp_q.size() == 1 && !exp_q[0][1]));
      exp_st  = exp_xv ? SHIFT : (m_done ? DONE : IDLE);

      check("x_valid", x_valid, exp_xv);
      check("x_out", x_out, exp_x);
      check("hit", hit, exp_hit);
      check("done", done, m_done);
      check("in_ready", in_ready, exp_rdy);
      check("state", state_dbg, exp_st);
      check("hit_count", hit_count, sat(m_count, 255));
      check("hit_count_sat", hit_count_s, sat(m_count, 3));
`ifdef HIT_POS_EN
      check("hit_pos", hit_pos, m_hitpos);
`endif

      handshake = in_valid && exp_rdy;
      if (clear) begin
        model_reset();
      end else begin
        done_next = 0;
        if (m_done) begin
          win_q.delete();
          m_pkt_open = 0;
        end
        if (exp_xv) begin
          e = exp_q.pop_front();
          if (exp_hit) begin
            m_count++;
            hit_log.push_back(m_bitidx);
            m_hitpos = m_bitidx;
          end
          if (exp_hit && !m_ovl) win_q.delete();
          else                   win_q.push_back(exp_x);
          m_bitidx = (m_bitidx + 1) % 65536;
          if (e[1]) done_next = 1;
        end
        if (handshake) begin
          if (!m_pkt_open) begin
            m_count = 0; m_bitidx = 0; m_hitpos = 0;
            m_ovl = mode_ovl; m_pkt_open = 1;
            hit_log.delete();
          end
          for (int i = WORD_W - 1; i >= 0; i--)
            exp_q.push_back({(i == 0) && in_last, in_data[i]});
        end
        m_done = done_next;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [7:0] d, input logic l, input logic o);
    int n = 0;
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_last = l; mode_ovl = o;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("handshake_seen", ok, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check("done_seen", seen, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal pins on the model's hit list and the DUT count.
  task automatic check_hits(input string name, input int n, input int a, input int b, input int cnt);
    int v0, v1;
    v0 = (hit_log.size() > 0) ? hit_log[0] : -1;
    v1 = (hit_log.size() > 1) ? hit_log[1] : -1;
    check({name, "_nhits"}, hit_log.size(), n);
    check({name, "_hit0"}, v0, a);
    check({name, "_hit1"}, v1, b);
    check({name, "_count"}, hit_count, cnt);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_x_valid", x_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_hit", hit, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hit_count", hit_count, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    idle(2);

    // Overlap, single word: hits at bits 3 and 6
    send_word(8'b1011_0110, 1'b1, 1'b1);
    wait_done();
    check_hits("ovl1", 2, 3, 6, 2);
    idle(3);
    check("ovl1_hold", hit_count, 2);

    // Non-overlap, same word: one hit at bit 3
    send_word(8'b1011_0110, 1'b1, 1'b0);
    wait_done();
    check_hits("novl1", 1, 3, -1, 1);
    idle(2);

    // Back-to-back words, pattern across the word boundary
    send_word(8'b0000_0010, 1'b0, 1'b1);
    send_word(8'b1100_0000, 1'b1, 1'b1);
    wait_done();
    check_hits("xword", 1, 9, -1, 1);
`ifdef HIT_POS_EN
    check("xword_hit_pos", hit_pos, 9);
`endif
    idle(2);

    // Saturation: four hits, 2-bit counter holds at 3
    send_word(8'b1011_1011, 1'b0, 1'b1);
    send_word(8'b1011_1011, 1'b1, 1'b1);
    wait_done();
    check("sat_count_full", hit_count, 4);
    check("sat_count_2b", hit_count_s, 3);
    idle(2);

    // Idle gap inside a packet: history survives the gap
    send_word(8'b0100_0010, 1'b0, 1'b1);
    idle(12);
    check("gap_x_valid", x_valid, 0);
    send_word(8'b1100_0000, 1'b1, 1'b1);
    wait_done();
    check_hits("gap", 1, 9, -1, 1);
    idle(2);

    // Async reset while bit 4 is on the wire
    send_word(8'b1011_0110, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_x_valid", x_valid, 0);
    check("arst_hit", hit, 0);
    check("arst_done", done, 0);
    check("arst_hit_count", hit_count, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    idle(12);

    // Clear mid-SHIFT after a hit was counted, then a fresh packet
    send_word(8'b1011_0110, 1'b1, 1'b1);
    idle(5);
    check("clr_pre_count", hit_count, 1);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("clr_count", hit_count, 0);
    check("clr_x_valid", x_valid, 0);
    idle(12);
    send_word(8'b1011_0000, 1'b1, 1'b0);
    wait_done();
    check_hits("post_clr", 1, 3, -1, 1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
